// File: rtl/combo_checker.sv
// combo_checker
//   Consumer side of the switch/press entry path. The raw press button is
//   synchronised and edge-detected. On each clean press edge the 16 switches
//   are compared with the stored combination, and the lock state
//   (LOCKED / UNLOCKED / LOCKOUT) is driven from the result. While UNLOCKED,
//   a press with set_code held stores the switches as the new combination.
//
//   Optional feature macro: COMBO_LOCKOUT_EN
//     defined   : reaching MAX_FAIL consecutive wrong entries enters LOCKOUT
//                 for LOCKOUT_CYCLES clocks, and presses are ignored there.
//     undefined : LOCKOUT is not built and lockout is tied low. Wrong entries
//                 keep pulsing fail_pulse while fail_count holds at MAX_FAIL.
//
// Parameters
//   WIDTH          code width (= switch count)
//   DEFAULT_CODE   combination loaded at reset
//   MAX_FAIL       consecutive wrong entries before lockout / saturation
//   UNLOCK_CYCLES  idle clocks in UNLOCKED before automatic relock
//   LOCKOUT_CYCLES clocks spent in LOCKOUT
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   press       in   raw entry button, asynchronous to clk
//   switch      in   [WIDTH]  entered code, static around the press
//   set_code    in   level; a press while UNLOCKED stores a new code
//   unlocked    out  1 while UNLOCKED
//   lockout     out  1 while LOCKOUT (always 0 when the feature is off)
//   fail_pulse  out  1-cycle pulse per wrong entry
//   code_saved  out  1-cycle pulse when a new code is stored
//   fail_count  out  [$clog2(MAX_FAIL+1)]  consecutive wrong entries

module combo_checker #(
  parameter int               WIDTH          = 16,
  parameter logic [WIDTH-1:0] DEFAULT_CODE   = 16'h1234,
  parameter int               MAX_FAIL       = 3,
  parameter int               UNLOCK_CYCLES  = 500000000,
  parameter int               LOCKOUT_CYCLES = 100000000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            press,
  input  logic [WIDTH-1:0]                switch,
  input  logic                            set_code,
  output logic                            unlocked,
  output logic                            lockout,
  output logic                            fail_pulse,
  output logic                            code_saved,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count
);

  localparam int FCW  = $clog2(MAX_FAIL + 1);
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [FCW-1:0] FAIL_SAT    = FCW'(MAX_FAIL);
  localparam logic [TW-1:0]  UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);

  localparam logic [1:0] ST_LOCKED   = 2'd0;
  localparam logic [1:0] ST_UNLOCKED = 2'd1;
`ifdef COMBO_LOCKOUT_EN
  localparam logic [1:0] ST_LOCKOUT  = 2'd2;
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
`endif

  // Saturating increment: the consecutive-failure count never wraps.
  function automatic logic [FCW-1:0] sat_inc(input logic [FCW-1:0] v);
    return (v >= FAIL_SAT) ? v : v + 1'b1;
  endfunction

  logic             s1, s2, s3;
  logic             evt;
  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] code, code_nxt;
  logic [FCW-1:0]   fcnt, fcnt_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic             fail_nxt, saved_nxt;

  // Press synchroniser: s1/s2 resolve metastability, s3 is the edge-detect
  // history. evt is one cycle per rising edge, however long press is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= press;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign evt = s2 & ~s3;

  // Next-state decode. switch is used directly in the evt cycle; the user
  // holds it static around the press, so no capture register is needed.
  always_comb begin
    state_nxt = state;
    code_nxt  = code;
    fcnt_nxt  = fcnt;
    timer_nxt = timer;
    fail_nxt  = 1'b0;
    saved_nxt = 1'b0;
    case (state)
      ST_LOCKED: begin
        if (evt) begin
          if (switch == code) begin
            state_nxt = ST_UNLOCKED;
            fcnt_nxt  = '0;
            timer_nxt = UNLOCK_LOAD;
          end else begin
            fail_nxt = 1'b1;
            fcnt_nxt = sat_inc(fcnt);
`ifdef COMBO_LOCKOUT_EN
            if (sat_inc(fcnt) == FAIL_SAT) begin
              state_nxt = ST_LOCKOUT;
              timer_nxt = LOCKOUT_LOAD;
            end
`endif
          end
        end
      end

      // A press always takes priority over the idle timer expiring in the
      // same cycle, so the two can never produce conflicting results.
      ST_UNLOCKED: begin
        if (evt) begin
          if (set_code) begin
            code_nxt  = switch;
            saved_nxt = 1'b1;
            timer_nxt = UNLOCK_LOAD;
          end else begin
            state_nxt = ST_LOCKED;
            timer_nxt = '0;
          end
        end else if (timer == '0) begin
          state_nxt = ST_LOCKED;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end

`ifdef COMBO_LOCKOUT_EN
      // Presses are deliberately ignored here; fail_count stays at MAX_FAIL
      // until the penalty period expires.
      ST_LOCKOUT: begin
        if (timer == '0) begin
          state_nxt = ST_LOCKED;
          fcnt_nxt  = '0;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
`endif

      // Any unused encoding falls back to LOCKED on the next clock.
      default: begin
        state_nxt = ST_LOCKED;
        timer_nxt = '0;
      end
    endcase
  end

  // State, code, counters and the registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOCKED;
      code       <= DEFAULT_CODE;
      fcnt       <= '0;
      timer      <= '0;
      fail_pulse <= 1'b0;
      code_saved <= 1'b0;
    end else begin
      state      <= state_nxt;
      code       <= code_nxt;
      fcnt       <= fcnt_nxt;
      timer      <= timer_nxt;
      fail_pulse <= fail_nxt;
      code_saved <= saved_nxt;
    end
  end

  assign unlocked   = (state == ST_UNLOCKED);
  assign fail_count = fcnt;
`ifdef COMBO_LOCKOUT_EN
  assign lockout    = (state == ST_LOCKOUT);
`else
  assign lockout    = 1'b0;
`endif

endmodule

// File: tb/tb_combo_checker.sv
// tb_combo_checker
//   Directed bench for combo_checker with small timer values
//   (UNLOCK_CYCLES=20, LOCKOUT_CYCLES=10). The lockout sequences are built
//   only when COMBO_LOCKOUT_EN is defined; otherwise the saturation
//   behaviour without lockout is exercised.

module tb_combo_checker;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          press = 1'b0;
  logic [W-1:0]  switch = '0;
  logic          set_code = 1'b0;
  logic          unlocked, lockout, fail_pulse, code_saved;
  logic [1:0]    fail_count;

  int n_chk  = 0;
  int n_pass = 0;
  int n_failp = 0;
  int n_saved = 0;
  int base;

  combo_checker #(
    .WIDTH          (W),
    .DEFAULT_CODE   (16'h1234),
    .MAX_FAIL       (3),
    .UNLOCK_CYCLES  (20),
    .LOCKOUT_CYCLES (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .press      (press),
    .switch     (switch),
    .set_code   (set_code),
    .unlocked   (unlocked),
    .lockout    (lockout),
    .fail_pulse (fail_pulse),
    .code_saved (code_saved),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;

  // Pulse counters: each registered pulse is high across exactly one edge.
  always @(posedge clk) begin
    if (fail_pulse) n_failp++;
    if (code_saved) n_saved++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise press just after an edge; the state update lands on the third
  // following edge, and we return 1ns after it with press released.
  task automatic do_press(input logic [W-1:0] sw);
    switch = sw;
    press  = 1'b1;
    repeat (3) tick();
    press  = 1'b0;
  endtask

  task automatic gap();
    repeat (3) tick();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_unl"}, unlocked, 0);
    check({tag, "_lko"}, lockout, 0);
    check({tag, "_fp"},  fail_pulse, 0);
    check({tag, "_cs"},  code_saved, 0);
    check({tag, "_fc"},  fail_count, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check_idle("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // 1: correct default code unlocks on the third edge
    switch = 16'h1234;
    press  = 1'b1;
    tick(); tick();
    check("t1_early_unl", unlocked, 0);
    tick();
    check("t1_unl", unlocked, 1);
    check("t1_fc", fail_count, 0);
    press = 1'b0;
    gap();
    do_press(16'h0000);             // relock, switch ignored
    check("t1_relock", unlocked, 0);
    check("t1_relock_fp", fail_pulse, 0);
    gap();

    // 2: two wrong entries then the right one
    base = n_failp;
    do_press(16'hBEEF);
    check("t2_fp1", fail_pulse, 1);
    check("t2_fc1", fail_count, 1);
    tick();
    check("t2_fp1_end", fail_pulse, 0);
    gap();
    do_press(16'hBEEF);
    check("t2_fc2", fail_count, 2);
    check("t2_locked", unlocked, 0);
    gap();
    check("t2_npulse", n_failp - base, 2);
    do_press(16'h1234);
    check("t2_unl", unlocked, 1);
    check("t2_fc0", fail_count, 0);
    gap();

    // 3: store a new code while unlocked
    base = n_saved;
    set_code = 1'b1;
    do_press(16'hA5A5);
    check("t3_saved", code_saved, 1);
    check("t3_still_unl", unlocked, 1);
    tick();
    check("t3_saved_end", code_saved, 0);
    set_code = 1'b0;
    gap();
    check("t3_nsaved", n_saved - base, 1);
    do_press(16'h1234);             // relock, value ignored
    check("t3_relock", unlocked, 0);
    check("t3_relock_fp", fail_pulse, 0);
    gap();
    do_press(16'h1234);
    check("t3_old_fails", fail_pulse, 1);
    check("t3_old_unl", unlocked, 0);
    gap();
    do_press(16'hA5A5);
    check("t3_new_unl", unlocked, 1);
    check("t3_new_fc", fail_count, 0);

    // 6b: reset mid-UNLOCKED after a code change
    rst_n = 1'b0;
    #2;
    check_idle("t6u");
    tick();
    rst_n = 1'b1;
    gap();
    do_press(16'hA5A5);
    check("t6u_a5_fails", fail_pulse, 1);
    gap();
    do_press(16'h1234);
    check("t6u_def_unl", unlocked, 1);

    // 4: idle auto-relock after 20 cycles (we are 1ns past the unlock edge)
    repeat (19) tick();
    check("t4_unl_19", unlocked, 1);
    tick();
    check("t4_relock_20", unlocked, 0);
    check("t4_no_fp", fail_pulse, 0);
    gap();
    do_press(16'h1234);
    check("t4_unl2", unlocked, 1);
    // press lands on the same edge the timer would expire
    base = n_failp;
    repeat (17) tick();
    switch = 16'h5555;
    press  = 1'b1;
    tick(); tick();
    check("t4_evt_unl_19", unlocked, 1);
    tick();
    check("t4_evt_relock", unlocked, 0);
    check("t4_evt_cs", code_saved, 0);
    press = 1'b0;
    tick();
    check("t4_evt_nofp", n_failp - base, 0);
    check("t4_evt_stay", unlocked, 0);
    gap();

    // 5: repeated wrong entries
    base = n_failp;
`ifdef COMBO_LOCKOUT_EN
    for (int i = 0; i < 3; i++) begin
      do_press(16'hBEEF);
      if (i < 2) gap();
    end
    check("t5_lko", lockout, 1);
    check("t5_lko_fp", fail_pulse, 1);
    check("t5_lko_fc", fail_count, 3);
    gap();
    do_press(16'h1234);             // evt at lockout edge +6, ignored
    check("t5_ign_unl", unlocked, 0);
    check("t5_ign_lko", lockout, 1);
    check("t5_ign_fc", fail_count, 3);
    check("t5_ign_fp", fail_pulse, 0);
    repeat (3) tick();
    check("t5_lko_9", lockout, 1);
    tick();
    check("t5_lko_end", lockout, 0);
    check("t5_lko_fc0", fail_count, 0);
    tick();
    check("t5_npulse", n_failp - base, 3);
    gap();
    // 6a: reset mid-LOCKOUT
    for (int i = 0; i < 3; i++) begin
      do_press(16'h0BAD);
      if (i < 2) gap();
    end
    check("t6l_lko", lockout, 1);
    rst_n = 1'b0;
    #2;
    check_idle("t6l");
    tick();
    rst_n = 1'b1;
    gap();
`else
    for (int i = 0; i < 5; i++) begin
      do_press(16'hBEEF);
      gap();
    end
    check("t5_npulse", n_failp - base, 5);
    check("t5_fc_sat", fail_count, 3);
    check("t5_no_lko", lockout, 0);
    check("t5_locked", unlocked, 0);
`endif
    do_press(16'h1234);
    check("t5_unl", unlocked, 1);
    check("t5_fc0", fail_count, 0);
    gap();
    do_press(16'h0000);
    check("t5_relock", unlocked, 0);
    gap();

    // 6: holding press for 50 cycles gives one event
    base = n_failp;
    switch = 16'hBEEF;
    press  = 1'b1;
    repeat (50) tick();
    press  = 1'b0;
    gap();
    check("t6_hold_npulse", n_failp - base, 1);
    check("t6_hold_fc", fail_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
